// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: PC, single-outstanding imem fetch, IF/ID slot with one-entry fetch buffer.
// Optional immediate generator enabled by defining FETCH_IMM_GEN_EN; otherwise imm is tied to zero.
module instr_fetch_decode #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_valid,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                id_valid,
  output logic [PC_WIDTH-1:0] id_pc,
  output logic [31:0]         id_instr,
  output logic [6:0]          Opcode,
  output logic [3:0]          Funct,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [31:0]         imm,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  id_valid_q, id_valid_d;
  logic [PC_WIDTH-1:0]   id_pc_q, id_pc_d;
  logic [31:0]           id_instr_q, id_instr_d;
  logic [31:0]           fbuf_q, fbuf_d;
  logic                  slot_free;
  logic                  unused_bits;

  // Handshakes: imem_req is a one-cycle strobe, imem_valid answers it >=1 cycle later with no
  // backpressure; the IF/ID slot is consumed by downstream in any cycle with id_valid && !stall.
  assign slot_free = !id_valid_q || !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      fbuf_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      fbuf_q     <= fbuf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    fbuf_d     = fbuf_q;
    // A consumed slot empties unless something new is loaded below.
    if (slot_free) id_valid_d = 1'b0;
    if (branch_taken) begin
      pc_d       = {branch_target[PC_WIDTH-1:2], 2'b00};
      id_valid_d = 1'b0;
      fbuf_d     = '0;
      case (state_q)
        S_REQ:   state_d = S_DRAIN;
        S_WAIT:  state_d = imem_valid ? S_REQ : S_DRAIN;
        S_DRAIN: state_d = imem_valid ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_BOOT: state_d = S_REQ;
        S_REQ:  state_d = S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            if (slot_free) begin
              id_valid_d = 1'b1;
              id_pc_d    = pc_q;
              id_instr_d = imem_rdata;
              pc_d       = pc_q + PC_WIDTH'(4);
              state_d    = S_REQ;
            end else begin
              fbuf_d  = imem_rdata;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (slot_free) begin
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_instr_d = fbuf_q;
            fbuf_d     = '0;
            pc_d       = pc_q + PC_WIDTH'(4);
            state_d    = S_REQ;
          end
        end
        S_DRAIN: if (imem_valid) state_d = S_REQ;
        default: state_d = S_BOOT;
      endcase
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign dbg_state_o = state_q;

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;
  // Bubble: control unit sees opcode/funct of zero when the slot is empty.
  assign Opcode   = id_valid_q ? id_instr_q[6:0] : 7'd0;
  assign Funct    = id_valid_q ? {id_instr_q[30], id_instr_q[14:12]} : 4'd0;
  assign rs1      = id_instr_q[19:15];
  assign rs2      = id_instr_q[24:20];
  assign rd       = id_instr_q[11:7];

`ifdef FETCH_IMM_GEN_EN
  logic [31:0] imm_gen;
  always_comb begin
    imm_gen = '0;
    if (id_valid_q) begin
      case (id_instr_q[6:0])
        7'b0010011, 7'b0000011, 7'b1100111:
          imm_gen = {{20{id_instr_q[31]}}, id_instr_q[31:20]};
        7'b0100011:
          imm_gen = {{20{id_instr_q[31]}}, id_instr_q[31:25], id_instr_q[11:7]};
        7'b1100011:
          imm_gen = {{19{id_instr_q[31]}}, id_instr_q[31], id_instr_q[7], id_instr_q[30:25],
                     id_instr_q[11:8], 1'b0};
        7'b0110111, 7'b0010111:
          imm_gen = {id_instr_q[31:12], 12'd0};
        7'b1101111:
          imm_gen = {{11{id_instr_q[31]}}, id_instr_q[31], id_instr_q[19:12], id_instr_q[20],
                     id_instr_q[30:21], 1'b0};
        default: imm_gen = '0;
      endcase
    end
  end
  assign imm = imm_gen;
`else
  assign imm = 32'h0;
`endif

  assign unused_bits = ^{branch_target[1:0], id_instr_q[31], id_instr_q[29:25]};

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Fetch-and-decode front end of the single-issue RISC-V datapath. Holds the PC, issues one instruction-memory request at a time, and registers each returned word into an IF/ID pipeline slot. The slot's fields (Opcode, Funct) feed the control-unit / ALU-control stage directly; rs1/rs2/rd/imm feed the register file and operand muxes. Handles downstream stall and branch redirect/flush.

## Interface
- PC_WIDTH, 32, width of PC and memory address
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- imem_req  out  1  request strobe, one cycle per request
- imem_addr  out  PC_WIDTH  request address, valid when imem_req=1
- imem_rdata  in  32  instruction word, valid when imem_valid=1
- imem_valid  in  1  response strobe, at least 1 cycle after imem_req
- stall  in  1  downstream cannot accept a new IF/ID slot this cycle
- branch_taken  in  1  redirect request
- branch_target  in  PC_WIDTH  redirect address
- id_valid  out  1  IF/ID slot holds a live instruction
- id_pc  out  PC_WIDTH  PC of slot instruction
- id_instr  out  32  slot instruction word
- Opcode  out  7  id_instr[6:0], 0 when id_valid=0
- Funct  out  4  {id_instr[30], id_instr[14:12]}, 0 when id_valid=0
- rs1, rs2, rd  out  5 each  id_instr[19:15], [24:20], [11:7]
- imm  out  32  sign-extended immediate (see Configuration)

## Operation
- Single outstanding request; one-entry fetch buffer (fbuf) behind the IF/ID slot.
- slot_free = !id_valid || !stall.
- States: BOOT, REQ, WAIT, HOLD, DRAIN.
  - BOOT: first cycle after reset release, no request; -> REQ.
  - REQ: imem_req=1, imem_addr=pc; -> WAIT.
  - WAIT: on imem_valid: if slot_free, load slot {pc, imem_rdata}, pc<=pc+4, -> REQ; else store in fbuf, -> HOLD. No imem_valid: stay. While slot_free and no new load, id_valid<=0.
  - HOLD: when slot_free, move fbuf to slot, pc<=pc+4, -> REQ.
  - DRAIN: discard next imem_valid (no slot/fbuf/pc update); -> REQ.
- branch_taken (any state, priority over stall and imem_valid): pc<=branch_target, id_valid<=0, fbuf cleared. From REQ or WAIT (response outstanding) -> DRAIN; if imem_valid arrives in the same cycle as branch_taken in WAIT, it is discarded and next state is REQ. From BOOT/HOLD/DRAIN -> REQ (DRAIN with no response yet stays DRAIN).
- PC arithmetic modulo 2^PC_WIDTH; bits [1:0] of branch_target ignored (forced 0).
- Opcode/Funct forced 0 when id_valid=0 so the control unit sees a bubble (all controls deasserted).

## Timing
- Reset (rst_n=0 at edge): state=BOOT, pc=RESET_PC, id_valid=0, id_pc=0, id_instr=0, fbuf empty, imem_req=0, imem_addr=RESET_PC, Opcode=0, Funct=0, rs1/rs2/rd=0, imm=0. Reset mid-operation drops any outstanding response; memory is reset on the same rst_n.
- First imem_req in cycle 2 after reset release.
- Fetch throughput: one instruction per (2 + memory latency - 1) cycles; with 1-cycle memory, one per 2 cycles.
- imem_valid → id_valid: 1 cycle (registered) when slot_free.
- Stall holds id_* and all decoded fields stable.
- Branch → first redirected fetch: imem_req with branch_target next cycle (no outstanding) or after drained response.

## Configuration
- FETCH_IMM_GEN_EN defined: imm decoded from id_instr by opcode: I (0010011, 0000011, 1100111), S (0100011), B (1100011, bit0=0), U (0110111, 0010111, low 12 bits 0), J (1101111, bit0=0); other opcodes or id_valid=0 -> 0.
- Undefined: imm tied to 32'h0; port remains.

## Test plan
- Reset then 1-cycle memory returning 32'h0020_8133 at 0: imem_req cycle 2 addr 0; id_valid=1, Opcode=7'h33, Funct=4'h0, rd=2, rs1=1, rs2=2; next request addr 4.
- Instruction 32'h4020_8133 (sub): Funct=4'b1000, Opcode=7'h33.
- stall=1 for 5 cycles with next response returned: slot unchanged, fbuf holds word, no imem_req; stall drop -> slot loads fbuf next cycle, request addr+4 follows.
- branch_taken with target 32'h0000_0100 while response outstanding: id_valid=0 next cycle, returned word discarded, next imem_addr=0x100.
- branch_taken and imem_valid same cycle, stall=1: flush wins, id_valid=0, pc=target.
- FETCH_IMM_GEN_EN, instr 32'hFFF0_0093 (addi x1,x0,-1): imm=32'hFFFF_FFFF; undefined: imm=0.
